formula_car_sprite_rom: RTL and testbench

//   Procedural 30x30 top-down formula-car sprite ROM, 12-bit RGB (4:4:4).
//   The display controller passes (vCount-ypos, hCount-xpos) as row/col and

---
 rtl/formula_car_sprite_rom.sv | 69 ++++++
 tb/tb_formula_car_sprite_rom.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/formula_car_sprite_rom.sv
// Procedural 30x30 top-down formula-car sprite ROM, 12-bit RGB, one-cycle registered read.
// Optional build macro FORMULA_CAR_ROM_STRIPE_EN adds a white centre stripe along the body.
module formula_car_sprite_rom #(
  parameter logic [11:0] KEY_COLOR  = 12'h0F0,
  parameter logic [11:0] BODY_COLOR = 12'hF00,
  parameter int          SPRITE_W   = 30,
  parameter int          SPRITE_H   = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  row,
  input  logic [9:0]  col,
  output logic [11:0] color_data
);

  localparam logic [9:0] SPRITE_W_L = SPRITE_W[9:0];
  localparam logic [9:0] SPRITE_H_L = SPRITE_H[9:0];

  logic [11:0] color_p1;

  function automatic logic in_rng(input logic [9:0] v, input logic [9:0] lo,
                                  input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Priority chain: earlier regions paint over later ones where they overlap.
  function automatic logic [11:0] pixel_color(input logic [9:0] r, input logic [9:0] c);
    logic [11:0] clr;
    logic        wheel_r;
    logic        wheel_c;
    clr     = KEY_COLOR;
    wheel_r = in_rng(r, 10'd5, 10'd10) || in_rng(r, 10'd19, 10'd26);
    wheel_c = in_rng(c, 10'd1, 10'd5)  || in_rng(c, 10'd24, 10'd28);
    if (r >= SPRITE_H_L || c >= SPRITE_W_L)
      clr = KEY_COLOR;
    else if (in_rng(r, 10'd0, 10'd2) && in_rng(c, 10'd3, 10'd26))
      clr = 12'hFFF;
    else if (in_rng(r, 10'd28, 10'd29) && in_rng(c, 10'd5, 10'd24))
      clr = 12'hFFF;
    else if (wheel_r && wheel_c)
      clr = 12'h000;
    else if (in_rng(r, 10'd13, 10'd15) && in_rng(c, 10'd13, 10'd16))
      clr = 12'hFF0;
    else if (in_rng(r, 10'd12, 10'd17) && in_rng(c, 10'd12, 10'd17))
      clr = 12'h222;
`ifdef FORMULA_CAR_ROM_STRIPE_EN
    else if (in_rng(r, 10'd18, 10'd27) && in_rng(c, 10'd14, 10'd15))
      clr = 12'hFFF;
`endif
    else if (in_rng(r, 10'd3, 10'd8) && in_rng(c, 10'd12, 10'd17))
      clr = BODY_COLOR;
    else if (in_rng(r, 10'd9, 10'd27) && in_rng(c, 10'd9, 10'd20))
      clr = BODY_COLOR;
    else
      clr = KEY_COLOR;
    return clr;
  endfunction

  // Stage p0 -> p1: combinational lookup registered on the sampling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      color_p1 <= KEY_COLOR;
    else
      color_p1 <= pixel_color(row, col);
  end

  assign color_data = color_p1;

endmodule

// File: tb/tb_formula_car_sprite_rom.sv
// Directed and sweep bench for formula_car_sprite_rom; region-table reference model.
module tb_formula_car_sprite_rom;

  logic        clk;
  logic        rst;
  logic [9:0]  row;
  logic [9:0]  col;
  logic [11:0] color_data;

  int total = 0;
  int bad   = 0;

`ifdef FORMULA_CAR_ROM_STRIPE_EN
  localparam bit STRIPE_ON = 1'b1;
`else
  localparam bit STRIPE_ON = 1'b0;
`endif

  formula_car_sprite_rom dut (
    .clk        (clk),
    .rst        (rst),
    .row        (row),
    .col        (col),
    .color_data (color_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Region table in priority order: front wing, rear wing, four wheels,
  // helmet, cockpit, stripe (index 8), nose, body.
  int          t_r0 [11] = '{0, 28, 5, 5, 19, 19, 13, 12, 18, 3, 9};
  int          t_r1 [11] = '{2, 29, 10, 10, 26, 26, 15, 17, 27, 8, 27};
  int          t_c0 [11] = '{3, 5, 1, 24, 1, 24, 13, 12, 14, 12, 9};
  int          t_c1 [11] = '{26, 24, 5, 28, 5, 28, 16, 17, 15, 17, 20};
  logic [11:0] t_clr[11] = '{12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000,
                             12'hFF0, 12'h222, 12'hFFF, 12'hF00, 12'hF00};

  function automatic logic [11:0] model(input int r, input int c);
    if (r >= 30 || c >= 30) return 12'h0F0;
    for (int i = 0; i < 11; i++) begin
      if (i == 8 && !STRIPE_ON) continue;
      if (r >= t_r0[i] && r <= t_r1[i] && c >= t_c0[i] && c <= t_c1[i])
        return t_clr[i];
    end
    return 12'h0F0;
  endfunction

  // Present an address at the falling edge so it is stable for the next rising edge.
  task automatic put(input int r, input int c);
    @(negedge clk);
    row = r[9:0];
    col = c[9:0];
  endtask

  task automatic test_reset();
    row = 10'd14;
    col = 10'd14;
    rst = 1'b1;
    #2;
    total++;
    if (color_data !== 12'h0F0) begin
      bad++;
      $display("FAIL reset_async got=%h want=%h", color_data, 12'h0F0);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (color_data !== 12'h0F0) begin
      bad++;
      $display("FAIL reset_held got=%h want=%h", color_data, 12'h0F0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_wings();
    int          vr [4] = '{0, 0, 29, 29};
    int          vc [4] = '{3, 2, 24, 25};
    logic [11:0] ve [4] = '{12'hFFF, 12'h0F0, 12'hFFF, 12'h0F0};
    for (int i = 0; i < 4; i++) begin
      put(vr[i], vc[i]);
      @(posedge clk);
      #1;
      total++;
      if (color_data !== ve[i]) begin
        bad++;
        $display("FAIL wing(%0d,%0d) got=%h want=%h", vr[i], vc[i], color_data, ve[i]);
      end
    end
  endtask

  task automatic test_regions();
    int          vr [8] = '{14, 12, 7, 20, 8, 9, 27, 28};
    int          vc [8] = '{14, 12, 3, 10, 12, 9, 20, 4};
    logic [11:0] ve [8] = '{12'hFF0, 12'h222, 12'h000, 12'hF00,
                            12'hF00, 12'hF00, 12'hF00, 12'h0F0};
    for (int i = 0; i < 8; i++) begin
      put(vr[i], vc[i]);
      @(posedge clk);
      #1;
      total++;
      if (color_data !== ve[i]) begin
        bad++;
        $display("FAIL region(%0d,%0d) got=%h want=%h", vr[i], vc[i], color_data, ve[i]);
      end
    end
  endtask

  task automatic test_stripe();
    logic [11:0] exp;
    exp = STRIPE_ON ? 12'hFFF : 12'hF00;
    put(20, 14);
    @(posedge clk);
    #1;
    total++;
    if (color_data !== exp) begin
      bad++;
      $display("FAIL stripe(20,14) got=%h want=%h", color_data, exp);
    end
  endtask

  task automatic test_out_of_range();
    int vr [4] = '{30, 0, 1023, 5};
    int vc [4] = '{0, 30, 5, 1023};
    for (int i = 0; i < 4; i++) begin
      put(vr[i], vc[i]);
      @(posedge clk);
      #1;
      total++;
      if (color_data !== 12'h0F0) begin
        bad++;
        $display("FAIL range(%0d,%0d) got=%h want=%h", vr[i], vc[i], color_data, 12'h0F0);
      end
    end
  endtask

  task automatic test_reset_midstream();
    put(0, 3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (color_data !== 12'h0F0) begin
      bad++;
      $display("FAIL mid_reset got=%h want=%h", color_data, 12'h0F0);
    end
    put(14, 14);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (color_data !== 12'hFF0) begin
      bad++;
      $display("FAIL post_release got=%h want=%h", color_data, 12'hFF0);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp;
    int          errs;
    errs = 0;
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < 30; c++) begin
        put(r, c);
        @(posedge clk);
        #1;
        exp = model(r, c);
        total++;
        if (color_data !== exp) begin
          bad++;
          if (errs < 10)
            $display("FAIL sweep(%0d,%0d) got=%h want=%h", r, c, color_data, exp);
          errs++;
        end
        if (r >= 9 && r <= 27 && c >= 9 && c <= 20) begin
          total++;
          if (color_data === 12'h0F0) begin
            bad++;
            $display("FAIL body_key(%0d,%0d) got=%h want=non-0F0", r, c, color_data);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    row = 10'd0;
    col = 10'd0;
    test_reset();
    test_wings();
    test_regions();
    test_stripe();
    test_out_of_range();
    test_reset_midstream();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
